ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 102 ++++++++++
 tb/tb_ram_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: CPU-side RAM controller that serialises instruction/data reads and stores onto a single RAM port
module ram_ctrl #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       cpu_addr,
   input  logic [DWIDTH-1:0] cpu_wdata,
   input  logic              addr_sel,
   input  logic              rd_req,
   input  logic              wr_req,
   output logic [DWIDTH-1:0] ins,
   output logic [DWIDTH-1:0] ldr_data,
   output logic              en_ram_out,
   output logic              busy,
   output logic              addr_err,
   output logic [AWIDTH-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);
   typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;
   localparam logic [2:0] LAST = 3'(RD_LAT - 1);
   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              sel_q, sel_d, oor_q, oor_d, re_q, re_d, we_q, we_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d, ins_q, ins_d, ldr_q, ldr_d, rdata;
   logic              accept, oor_in, cap;
   assign accept = state_q == IDLE && (rd_req || wr_req);
   assign oor_in = (cpu_addr >> AWIDTH) != 16'd0;
   assign cap    = state_q == RD_WAIT && cnt_q == LAST;
   assign rdata  = oor_q ? '0 : mem_rdata;
   // state and datapath registers, cleared asynchronously so a transaction in flight is abandoned
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         oor_q   <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ins_q   <= '0;
         ldr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         oor_q   <= oor_d;
         re_q    <= re_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ins_q   <= ins_d;
         ldr_q   <= ldr_d;
      end
   end
   // next state: writes win a collision, reads sit in RD_WAIT until the RAM data is due
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         IDLE:    state_d = wr_req ? WR : rd_req ? RD : IDLE;
         RD:      state_d = RD_WAIT;
         RD_WAIT: begin
            state_d = cap ? DONE : RD_WAIT;
            cnt_d   = cap ? 3'd0 : cnt_q + 3'd1;
         end
         WR:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // request latching, one-cycle RAM strobes (suppressed when out of range) and read capture
   always_comb begin
      addr_d  = accept ? cpu_addr[AWIDTH-1:0] : addr_q;
      wdata_d = accept ? cpu_wdata : wdata_q;
      sel_d   = accept ? addr_sel : sel_q;
      oor_d   = accept ? oor_in : oor_q;
      re_d    = accept && !wr_req && !oor_in;
      we_d    = accept && wr_req && !oor_in;
      ins_d   = cap && !sel_q ? rdata : ins_q;
      ldr_d   = cap && sel_q ? rdata : ldr_q;
   end
   // outputs decoded from the registered state
   always_comb begin
      en_ram_out = state_q == DONE;
      busy       = state_q != IDLE;
      addr_err   = state_q == DONE && oor_q;
      mem_addr   = addr_q;
      mem_re     = re_q;
      mem_we     = we_q;
      mem_wdata  = wdata_q;
      ins        = ins_q;
      ldr_data   = ldr_q;
   end
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: randomized check of ram_ctrl (RD_LAT 1 and 3) against a transaction-level model
module tb_ram_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr, cpu_wdata;
   logic        addr_sel, rd_req, wr_req;
   logic [15:0] ins [2], ldr [2], mem_wdata [2], mem_rdata [2];
   logic [7:0]  mem_addr [2];
   logic        en [2], busy [2], err [2], mem_re [2], mem_we [2];
   logic [15:0] ram [2][256];
   logic [15:0] dp [2][8];
   logic        vp [2][8];
   logic [15:0] junk;
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [15:0] pl_data;
   logic [15:0] exp_mem [256];
   logic [15:0] exp_ins, exp_ldr;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   ram_ctrl #(.DWIDTH(16), .AWIDTH(8), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .addr_sel(addr_sel),
      .rd_req(rd_req), .wr_req(wr_req), .ins(ins[0]), .ldr_data(ldr[0]), .en_ram_out(en[0]),
      .busy(busy[0]), .addr_err(err[0]), .mem_addr(mem_addr[0]), .mem_re(mem_re[0]),
      .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

   ram_ctrl #(.DWIDTH(16), .AWIDTH(8), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .addr_sel(addr_sel),
      .rd_req(rd_req), .wr_req(wr_req), .ins(ins[1]), .ldr_data(ldr[1]), .en_ram_out(en[1]),
      .busy(busy[1]), .addr_err(err[1]), .mem_addr(mem_addr[1]), .mem_re(mem_re[1]),
      .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

   function automatic int lat(input int u);
      return u == 0 ? 1 : 3;
   endfunction

   // RAM devices: data sampled with mem_re emerges RD_LAT edges later, junk otherwise
   always @(posedge clk) begin
      junk <= 16'($urandom);
      for (int u = 0; u < 2; u++) begin
         if (pl_en) ram[u][pl_addr] <= pl_data;
         else if (mem_we[u]) ram[u][mem_addr[u]] <= mem_wdata[u];
         dp[u][0] <= ram[u][mem_addr[u]];
         vp[u][0] <= mem_re[u];
         for (int i = 1; i < 8; i++) begin
            dp[u][i] <= dp[u][i-1];
            vp[u][i] <= vp[u][i-1];
         end
      end
   end

   always_comb begin
      for (int u = 0; u < 2; u++) mem_rdata[u] = vp[u][lat(u)-1] ? dp[u][lat(u)-1] : junk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("%s_data[%0d]", tag, u), {ins[u], ldr[u]}, 32'd0);
         chk($sformatf("%s_ctl[%0d]", tag, u),
             32'({en[u], busy[u], err[u], mem_re[u], mem_we[u], mem_addr[u], mem_wdata[u]}), 32'd0);
      end
   endtask

   // one request presented at the next edge; extra raises rd_req again while busy
   task automatic run(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                      input logic sel, input logic extra);
      int re_n [2], we_n [2], en_n [2], er_n [2], en_at [2];
      logic oor, isr, isw;
      logic [15:0] v;
      oor = addr[15:8] != 8'd0;
      isw = wr;
      isr = rd && !wr;
      for (int u = 0; u < 2; u++) begin
         re_n[u] = 0; we_n[u] = 0; en_n[u] = 0; er_n[u] = 0; en_at[u] = -1;
      end
      rd_req = rd; wr_req = wr; cpu_addr = addr; cpu_wdata = wd; addr_sel = sel;
      @(posedge clk); #1;
      rd_req = extra; wr_req = 1'b0;
      cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom); addr_sel = 1'($urandom);
      for (int c = 0; c < 16; c++) begin
         for (int u = 0; u < 2; u++) begin
            if (c == 0) chk($sformatf("busy[%0d]", u), 32'(busy[u]), 32'd1);
            if (mem_re[u]) begin
               re_n[u]++;
               chk($sformatf("re_addr[%0d]", u), 32'(mem_addr[u]), 32'(addr[7:0]));
               chk($sformatf("re_at[%0d]", u), 32'(c), 32'd0);
            end
            if (mem_we[u]) begin
               we_n[u]++;
               chk($sformatf("we_addr[%0d]", u), 32'(mem_addr[u]), 32'(addr[7:0]));
               chk($sformatf("we_data[%0d]", u), 32'(mem_wdata[u]), 32'(wd));
               chk($sformatf("we_at[%0d]", u), 32'(c), 32'd0);
            end
            if (en[u]) begin
               en_n[u]++;
               en_at[u] = c;
               chk($sformatf("err_done[%0d]", u), 32'(err[u]), 32'(oor));
            end
            if (err[u]) er_n[u]++;
         end
         if (c == 1) rd_req = 1'b0;
         @(posedge clk); #1;
      end
      if (isw && !oor) exp_mem[addr[7:0]] = wd;
      if (isr) begin
         v = oor ? 16'd0 : exp_mem[addr[7:0]];
         if (sel) exp_ldr = v;
         else exp_ins = v;
      end
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("re_cnt[%0d]", u), 32'(re_n[u]), 32'(isr && !oor));
         chk($sformatf("we_cnt[%0d]", u), 32'(we_n[u]), 32'(isw && !oor));
         chk($sformatf("en_cnt[%0d]", u), 32'(en_n[u]), 32'd1);
         chk($sformatf("en_lat[%0d]", u), 32'(en_at[u]), 32'(isw ? 1 : lat(u) + 1));
         chk($sformatf("err_cnt[%0d]", u), 32'(er_n[u]), 32'(oor));
         chk($sformatf("idle[%0d]", u), 32'(busy[u]), 32'd0);
         chk($sformatf("ins[%0d]", u), 32'(ins[u]), 32'(exp_ins));
         chk($sformatf("ldr[%0d]", u), 32'(ldr[u]), 32'(exp_ldr));
      end
      @(negedge clk);
   endtask

   initial begin
      int re_n [2], en_n [2], re2_at [2];
      logic [15:0] a;
      int k, p;
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; addr_sel = 1'b0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         pl_en = 1'b1;
         pl_addr = 8'(i);
         pl_data = i == 'h12 ? 16'hA5C3 : 16'($urandom);
         exp_mem[i] = pl_data;
      end
      @(negedge clk);
      pl_en = 1'b0;
      repeat (10) @(negedge clk);
      chk_zero("reset");
      exp_ins = '0;
      exp_ldr = '0;
      rst = 1'b0;
      run(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0);
      for (int u = 0; u < 2; u++) chk($sformatf("fetch[%0d]", u), 32'(ins[u]), 32'hA5C3);
      run(1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b0);
      run(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0);
      for (int u = 0; u < 2; u++) chk($sformatf("load[%0d]", u), 32'(ldr[u]), 32'h1234);
      run(1'b1, 1'b1, 16'h0055, 16'hBEEF, 1'b1, 1'b0);
      run(1'b1, 1'b0, 16'h0033, 16'h0000, 1'b0, 1'b1);
      run(1'b0, 1'b1, 16'h0021, 16'h5A5A, 1'b0, 1'b1);
      run(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0);
      for (int u = 0; u < 2; u++) chk($sformatf("oor_ldr[%0d]", u), 32'(ldr[u]), 32'd0);
      a = 16'($urandom_range(0, 255));
      rd_req = 1'b1; cpu_addr = a; addr_sel = 1'b1;
      for (int u = 0; u < 2; u++) begin
         re_n[u] = 0; en_n[u] = 0; re2_at[u] = -1;
      end
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         for (int u = 0; u < 2; u++) begin
            if (mem_re[u]) begin
               re_n[u]++;
               if (re_n[u] == 2) re2_at[u] = c;
            end
            if (en[u]) en_n[u]++;
         end
         if (c == 9) rd_req = 1'b0;
      end
      exp_ldr = exp_mem[a[7:0]];
      for (int u = 0; u < 2; u++) begin
         p = lat(u) + 3;
         chk($sformatf("hold_re[%0d]", u), 32'(re_n[u]), 32'((10 + p - 1) / p));
         chk($sformatf("hold_en[%0d]", u), 32'(en_n[u]), 32'((10 + p - 1) / p));
         chk($sformatf("hold_gap[%0d]", u), 32'(re2_at[u]), 32'(p));
         chk($sformatf("hold_ldr[%0d]", u), 32'(ldr[u]), 32'(exp_ldr));
      end
      @(negedge clk);
      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 3);
         a = $urandom_range(0, 9) == 0 ? 16'(256 + $urandom_range(0, 65279)) : 16'($urandom_range(0, 255));
         run(k != 2, k >= 2, a, 16'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      end
      rd_req = 1'b1; cpu_addr = 16'h0012; addr_sel = 1'b0;
      @(posedge clk); #1;
      rd_req = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      exp_ins = '0;
      exp_ldr = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
